// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter -- multi-digit packed BCD up/down counter.
//
// Each edge has one command, chosen in priority order: synchronous clear,
// then parallel load, then count. With none of them asserted the count holds.
// Carry and borrow ripple through all digits within one edge. A loaded digit
// above 9 is replaced by 0 and raises load_err for one cycle. chg pulses for
// one cycle whenever the registered count actually changed value.
//
// Optional feature macro: BCD_SAT_EN
//   undefined (default): counting past terminal count wraps
//                        (all-9s up -> all-0s, all-0s down -> all-9s).
//   defined            : counting at terminal count holds, and chg stays low.
//   In both builds tc is asserted at terminal count.

module bcd_updown_counter #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                en,
  input  logic                up,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                chg,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] count_q, count_d;
  logic         chg_q, chg_d;
  logic         load_err_q, load_err_d;

  logic [W-1:0] load_clean;
  logic         load_bad;
  logic [W-1:0] count_inc;
  logic [W-1:0] count_dec;
  logic         all_nine;
  logic         all_zero;
  logic         sat_hold;

  // Replace every non-BCD load digit with 0 and flag that it happened
  always_comb begin
    load_clean = '0;
    load_bad   = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_bad = 1'b1;
      end else begin
        load_clean[4*i +: 4] = load_val[4*i +: 4];
      end
    end
  end

  // Increment with the carry rippling through every digit in one edge
  always_comb begin
    logic carry;
    count_inc = count_q;
    carry     = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] >= 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Decrement with the borrow rippling through every digit in one edge
  always_comb begin
    logic borrow;
    count_dec = count_q;
    borrow    = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
  end

  // Detect the two terminal patterns: all digits 9, all digits 0
  always_comb begin
    all_nine = 1'b1;
    all_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (count_q[4*i +: 4] != 4'd9) all_nine = 1'b0;
      if (count_q[4*i +: 4] != 4'd0) all_zero = 1'b0;
    end
  end

  // Terminal count: depends only on en, up and the current count
  always_comb begin
    tc = en & ((up & all_nine) | (~up & all_zero));
  end

`ifdef BCD_SAT_EN
  // Saturating build: counting at terminal count is suppressed
  always_comb begin
    sat_hold = tc;
  end
`else
  // Wrapping build: the ripple increment/decrement wraps by itself
  always_comb begin
    sat_hold = 1'b0;
  end
`endif

  // Next-state selection, priority clr > load > en; chg follows any change
  always_comb begin
    count_d    = count_q;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d    = load_clean;
      load_err_d = load_bad;
    end else if (en && !sat_hold) begin
      count_d = up ? count_inc : count_dec;
    end
    chg_d = (count_d != count_q);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      chg_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      chg_q      <= chg_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign chg      = chg_q;
  assign load_err = load_err_q;

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 2, the number of BCD digits (legal 1..4).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port clr  input  1  synchronous clear to zero.
REQ-005 SHALL have port load  input  1  synchronous parallel load of load_val.
REQ-006 SHALL have port load_val  input  4*DIGITS  packed BCD load value; digit 0 in bits [3:0].
REQ-007 SHALL have port en  input  1  count enable.
REQ-008 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 SHALL have port count  output  4*DIGITS  registered packed BCD count, feeding per-digit BCD-to-Excess-3 converters downstream.
REQ-010 SHALL have port tc  output  1  terminal count, combinational.
REQ-011 SHALL have port chg  output  1  registered one-cycle pulse: count changed on the previous edge.
REQ-012 SHALL have port load_err  output  1  registered one-cycle pulse: previous load contained a non-BCD digit.

Function
REQ-013 SHALL apply priority per edge: clr > load > en; with none asserted, count holds.
REQ-014 SHALL on clr set count to 0 and clear load_err; chg pulses only if count was non-zero.
REQ-015 SHALL on load copy each digit of load_val; any digit >9 loads as 0 and sets load_err for one cycle; chg pulses only if the loaded value differs from the previous count.
REQ-016 SHALL on en & up increment digit 0; a digit at 9 becomes 0 and carries into the next digit in the same cycle (ripple within one edge, no extra latency).
REQ-017 SHALL on en & !up decrement digit 0; a digit at 0 becomes 9 and borrows from the next digit in the same cycle.
REQ-018 SHALL compute tc = en & ((up & all digits 9) | (!up & all digits 0)), independent of clr/load.
REQ-019 SHALL at terminal count without BCD_SAT_EN wrap: all-9s up -> all-0s; all-0s down -> all-9s; chg pulses.
REQ-020 SHALL keep every digit of count in 0..9 at all times after reset.
REQ-021 SHALL have latency one edge: a command sampled at edge N is visible on count after edge N; chg/load_err assert after the same edge and deassert on the next edge unless re-triggered.
REQ-022 SHALL treat a direction change on any cycle as taking effect on that same edge, with no state retained from the prior direction.

Reset
REQ-023 SHALL on rst_n low, immediately and independently of clk, force count = 0, chg = 0, load_err = 0.
REQ-024 SHALL abort any in-progress operation on reset; the first edge after rst_n deasserts is evaluated normally.

Configuration
REQ-025 SHALL honour macro BCD_SAT_EN: when defined, counting at terminal count holds (all-9s up, all-0s down), chg does not pulse, tc still asserts; when undefined, wrap per REQ-019.

Verification (DIGITS=2)
REQ-026 SHALL check: reset, then en=1 up=1 for 100 edges -> count 00,01..09,10..99,00; tc high only while count=99; chg every edge.
REQ-027 SHALL check: load 8'h10, en=1 up=0 -> 09 after one edge, 08 after the next; load 8'h00 then en down -> 99 (wrap) or 00 held with BCD_SAT_EN, chg low in the saturated case.
REQ-028 SHALL check: load 8'h3C -> count 8'h30, load_err high exactly one cycle; load 8'hF9 -> 8'h09, load_err pulses.
REQ-029 SHALL check: clr, load and en all high at one edge with load_val 8'h55 -> count 00; load+en with 8'h55 -> count 55 (no increment).
REQ-030 SHALL check: rst_n pulsed low between clock edges at count 47 -> count 00 before the next edge; counting resumes 01 on the first enabled edge after release.
